exec_unit: RTL and testbench

Parametrised, multi-cycle execute stage for the next-generation TD4-style core. Holds the architectural state: general registers, output latch, program counter and carry flag. Accepts one decoded instruction at a time over a valid/ready handshake. Single-cycle ops retire on the accept edge. Iterative shifts run one bit per cycle, with the handshake stalled until they finish.

---
 rtl/exec_unit.sv | 188 ++++++++++++++++++
 tb/tb_exec_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Execute stage of the TD4-style core: register file, output latch, PC and carry.
// Single-cycle ops retire on the accept edge; SHL/SHR iterate one bit per cycle.
module exec_unit #(
   parameter  int DATA_W = 4,
   parameter  int ADDR_W = 4,
   parameter  int NREG   = 2,
   localparam int RSEL_W = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [3:0]        op,
   input  logic [RSEL_W-1:0] rd,
   input  logic [RSEL_W-1:0] rs,
   input  logic [DATA_W-1:0] imm,
   input  logic [DATA_W-1:0] in_port,
   output logic [DATA_W-1:0] out_port,
   output logic [ADDR_W-1:0] pc,
   output logic              carry,
   output logic              retire,
   input  logic [RSEL_W-1:0] dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [DATA_W-1:0] KMAX_IMM = DATA_W'(DATA_W);
   localparam logic [CNT_W-1:0]  KMAX_CNT = CNT_W'(DATA_W);

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_MOVR = 4'd1;
   localparam logic [3:0] OP_MOVI = 4'd2;
   localparam logic [3:0] OP_IN   = 4'd3;
   localparam logic [3:0] OP_OUTR = 4'd4;
   localparam logic [3:0] OP_OUTI = 4'd5;
   localparam logic [3:0] OP_ADDI = 4'd6;
   localparam logic [3:0] OP_ADDR = 4'd7;
   localparam logic [3:0] OP_SHL  = 4'd8;
   localparam logic [3:0] OP_SHR  = 4'd9;
   localparam logic [3:0] OP_JMP  = 4'd10;
   localparam logic [3:0] OP_JNC  = 4'd11;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t              state_reg, state_next;
   logic [DATA_W-1:0]   regs_reg [NREG];
   logic [DATA_W-1:0]   regs_next [NREG];
   logic [DATA_W-1:0]   out_reg, out_next;
   logic [ADDR_W-1:0]   pc_reg, pc_next;
   logic                carry_reg, carry_next;
   logic                retire_reg, retire_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [RSEL_W-1:0]   srd_reg, srd_next;
   logic                sleft_reg, sleft_next;

   logic [DATA_W-1:0]   add_opnd;
   logic [DATA_W:0]     sum;
   logic [CNT_W-1:0]    kamt;
   logic [ADDR_W-1:0]   pc_inc;
   logic [ADDR_W-1:0]   jmp_tgt;
   logic [DATA_W-1:0]   shift_src;
   logic [DATA_W-1:0]   shifted;
   logic                shift_bit;

   assign instr_ready = (state_reg == IDLE);
   assign out_port    = out_reg;
   assign pc          = pc_reg;
   assign carry       = carry_reg;
   assign retire      = retire_reg;
   assign dbg_data    = regs_reg[dbg_sel];

   assign add_opnd = (op == OP_ADDR) ? regs_reg[rs] : imm;
   assign sum      = {1'b0, regs_reg[rd]} + {1'b0, add_opnd};
   assign pc_inc   = pc_reg + 1'b1;

   // Shifts longer than the data width behave like a full-width shift.
   always_comb begin
      if (imm >= KMAX_IMM) begin
         kamt = KMAX_CNT;
      end else begin
         kamt = imm[CNT_W-1:0];
      end
   end

   // Jump target: immediate zero-extended or truncated to the PC width.
   always_comb begin
      jmp_tgt = '0;
      for (int i = 0; i < ADDR_W && i < DATA_W; i++) begin
         jmp_tgt[i] = imm[i];
      end
   end

   assign shift_src = regs_reg[srd_reg];
   assign shifted   = sleft_reg ? {shift_src[DATA_W-2:0], 1'b0}
                                : {1'b0, shift_src[DATA_W-1:1]};
   assign shift_bit = sleft_reg ? shift_src[DATA_W-1] : shift_src[0];

   always_comb begin
      state_next  = state_reg;
      regs_next   = regs_reg;
      out_next    = out_reg;
      pc_next     = pc_reg;
      carry_next  = carry_reg;
      retire_next = 1'b0;
      cnt_next    = cnt_reg;
      srd_next    = srd_reg;
      sleft_next  = sleft_reg;

      case (state_reg)
         IDLE: begin
            if (instr_valid) begin
               retire_next = 1'b1;
               pc_next     = pc_inc;
               carry_next  = 1'b0;
               case (op)
                  OP_NOP:  ;
                  OP_MOVR: regs_next[rd] = regs_reg[rs];
                  OP_MOVI: regs_next[rd] = imm;
                  OP_IN:   regs_next[rd] = in_port;
                  OP_OUTR: out_next = regs_reg[rs];
                  OP_OUTI: out_next = imm;
                  OP_ADDI, OP_ADDR: {carry_next, regs_next[rd]} = sum;
                  OP_SHL, OP_SHR: begin
                     // Nonzero shifts leave architectural state untouched on accept.
                     if (kamt != '0) begin
                        retire_next = 1'b0;
                        pc_next     = pc_reg;
                        carry_next  = carry_reg;
                        state_next  = SHIFT;
                        cnt_next    = kamt;
                        srd_next    = rd;
                        sleft_next  = (op == OP_SHL);
                     end
                  end
                  OP_JMP:  pc_next = jmp_tgt;
                  OP_JNC: begin
                     if (!carry_reg) begin
                        pc_next = jmp_tgt;
                     end
                  end
                  default: ;
               endcase
            end
         end
         SHIFT: begin
            regs_next[srd_reg] = shifted;
            cnt_next           = cnt_reg - 1'b1;
            if (cnt_reg == CNT_W'(1)) begin
               carry_next  = shift_bit;
               pc_next     = pc_inc;
               retire_next = 1'b1;
               state_next  = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         for (int i = 0; i < NREG; i++) begin
            regs_reg[i] <= '0;
         end
         out_reg    <= '0;
         pc_reg     <= '0;
         carry_reg  <= 1'b0;
         retire_reg <= 1'b0;
         cnt_reg    <= '0;
         srd_reg    <= '0;
         sleft_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         regs_reg   <= regs_next;
         out_reg    <= out_next;
         pc_reg     <= pc_next;
         carry_reg  <= carry_next;
         retire_reg <= retire_next;
         cnt_reg    <= cnt_next;
         srd_reg    <= srd_next;
         sleft_reg  <= sleft_next;
      end
   end

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: two parameter sets checked against an arithmetic model
// using directed test-plan sequences followed by randomized instruction streams.
module tb_exec_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Instance A: DATA_W=4, ADDR_W=4, NREG=2
   logic       a_valid, a_ready, a_rd, a_rs, a_carry, a_retire, a_dbg;
   logic [3:0] a_op, a_imm, a_in, a_out, a_pc, a_dbgd;
   // Instance B: DATA_W=8, ADDR_W=6, NREG=4
   logic       b_valid, b_ready, b_carry, b_retire;
   logic [3:0] b_op;
   logic [1:0] b_rd, b_rs, b_dbg;
   logic [7:0] b_imm, b_in, b_out, b_dbgd;
   logic [5:0] b_pc;

   exec_unit #(.DATA_W(4), .ADDR_W(4), .NREG(2)) u_a (
      .clk(clk), .rst_n(rst_n), .instr_valid(a_valid), .instr_ready(a_ready),
      .op(a_op), .rd(a_rd), .rs(a_rs), .imm(a_imm), .in_port(a_in),
      .out_port(a_out), .pc(a_pc), .carry(a_carry), .retire(a_retire),
      .dbg_sel(a_dbg), .dbg_data(a_dbgd)
   );

   exec_unit #(.DATA_W(8), .ADDR_W(6), .NREG(4)) u_b (
      .clk(clk), .rst_n(rst_n), .instr_valid(b_valid), .instr_ready(b_ready),
      .op(b_op), .rd(b_rd), .rs(b_rs), .imm(b_imm), .in_port(b_in),
      .out_port(b_out), .pc(b_pc), .carry(b_carry), .retire(b_retire),
      .dbg_sel(b_dbg), .dbg_data(b_dbgd)
   );

   int checks = 0;
   int errors = 0;

   // Architectural model, one slot per instance.
   int m_regs [2][4];
   int m_out  [2];
   int m_pc   [2];
   int m_carry[2];

   function automatic int dw(int u);   return (u == 0) ? 4 : 8; endfunction
   function automatic int aw(int u);   return (u == 0) ? 4 : 6; endfunction
   function automatic int nreg(int u); return (u == 0) ? 2 : 4; endfunction

   function automatic logic get_ready(int u);  return (u == 0) ? a_ready : b_ready;   endfunction
   function automatic logic get_retire(int u); return (u == 0) ? a_retire : b_retire; endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         for (int r = 0; r < 4; r++) m_regs[u][r] = 0;
         m_out[u] = 0; m_pc[u] = 0; m_carry[u] = 0;
      end
   endtask

   // Applies one instruction to the model; returns the iterative shift length (0 = single cycle).
   function automatic int model_step(int u, int op, int rd, int rs, int imm, int inval);
      int mask  = (1 << dw(u)) - 1;
      int amask = (1 << aw(u)) - 1;
      int npc   = (m_pc[u] + 1) & amask;
      int nc    = 0;
      int k     = 0;
      int s, v;
      rd = rd % nreg(u); rs = rs % nreg(u);
      imm = imm & mask; inval = inval & mask;
      case (op)
         1: m_regs[u][rd] = m_regs[u][rs];
         2: m_regs[u][rd] = imm;
         3: m_regs[u][rd] = inval;
         4: m_out[u] = m_regs[u][rs];
         5: m_out[u] = imm;
         6, 7: begin
            s = m_regs[u][rd] + ((op == 6) ? imm : m_regs[u][rs]);
            nc = s >> dw(u);
            m_regs[u][rd] = s & mask;
         end
         8, 9: begin
            k = (imm < dw(u)) ? imm : dw(u);
            v = m_regs[u][rd];
            if (k > 0) begin
               if (op == 8) begin
                  nc = (v >> (dw(u) - k)) & 1;
                  m_regs[u][rd] = (v << k) & mask;
               end else begin
                  nc = (v >> (k - 1)) & 1;
                  m_regs[u][rd] = v >> k;
               end
            end
         end
         10: npc = imm & amask;
         11: if (m_carry[u] == 0) npc = imm & amask;
         default: ;
      endcase
      m_pc[u] = npc;
      m_carry[u] = nc;
      return k;
   endfunction

   task automatic drive(int u, logic v, int op, int rd, int rs, int imm, int inval);
      if (u == 0) begin
         a_valid = v; a_op = 4'(op); a_rd = 1'(rd); a_rs = 1'(rs);
         a_imm = 4'(imm); a_in = 4'(inval);
      end else begin
         b_valid = v; b_op = 4'(op); b_rd = 2'(rd); b_rs = 2'(rs);
         b_imm = 8'(imm); b_in = 8'(inval);
      end
   endtask

   task automatic drive_junk(int u, logic v);
      drive(u, v, $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 255), $urandom_range(0, 255));
   endtask

   task automatic peek(int u, int r, output logic [31:0] val);
      if (u == 0) begin a_dbg = 1'(r); #1; val = 32'(a_dbgd); end
      else        begin b_dbg = 2'(r); #1; val = 32'(b_dbgd); end
   endtask

   task automatic compare_state(int u);
      logic [31:0] val;
      check($sformatf("u%0d_ready", u), 32'(get_ready(u)), 32'd1);
      if (u == 0) begin
         check("u0_pc", 32'(a_pc), 32'(m_pc[0]));
         check("u0_carry", 32'(a_carry), 32'(m_carry[0]));
         check("u0_out", 32'(a_out), 32'(m_out[0]));
      end else begin
         check("u1_pc", 32'(b_pc), 32'(m_pc[1]));
         check("u1_carry", 32'(b_carry), 32'(m_carry[1]));
         check("u1_out", 32'(b_out), 32'(m_out[1]));
      end
      for (int r = 0; r < nreg(u); r++) begin
         peek(u, r, val);
         check($sformatf("u%0d_r%0d", u, r), val, 32'(m_regs[u][r]));
      end
   endtask

   // Issues one instruction; shifts keep instr_valid high with junk to prove stalled inputs are ignored.
   task automatic issue(int u, int op, int rd, int rs, int imm, int inval);
      int k;
      int low;
      drive(u, 1'b1, op, rd, rs, imm, inval);
      k = model_step(u, op, rd, rs, imm, inval);
      @(posedge clk); #1;
      if (k == 0) begin
         drive_junk(u, 1'b0);
         check("retire_single", 32'(get_retire(u)), 32'd1);
      end else begin
         drive_junk(u, 1'b1);
         low = 0;
         while (get_ready(u) === 1'b0 && low < 40) begin
            check("retire_busy", 32'(get_retire(u)), 32'd0);
            low++;
            @(posedge clk); #1;
         end
         drive_junk(u, 1'b0);
         check("stall_cycles", 32'(low), 32'(k));
         check("retire_shift", 32'(get_retire(u)), 32'd1);
      end
      compare_state(u);
      $display("txn u%0d op=%0d rd=%0d rs=%0d imm=%0h k=%0d pc=%0h carry=%0d",
               u, op, rd, rs, imm, k, m_pc[u], m_carry[u]);
   endtask

   task automatic idle(int u);
      drive_junk(u, 1'b0);
      @(posedge clk); #1;
      check("retire_idle", 32'(get_retire(u)), 32'd0);
      compare_state(u);
      $display("txn u%0d idle pc=%0h", u, m_pc[u]);
   endtask

   task automatic check_reset_state();
      model_reset();
      check("rst_retire_a", 32'(a_retire), 32'd0);
      check("rst_retire_b", 32'(b_retire), 32'd0);
      compare_state(0);
      compare_state(1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired before the end of the run");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] val;
      int u, op, imm;
      drive(0, 1'b0, 0, 0, 0, 0, 0);
      drive(1, 1'b0, 0, 0, 0, 0, 0);
      a_dbg = 1'b0; b_dbg = 2'd0;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      check_reset_state();
      @(negedge clk); rst_n = 1'b1;
      $display("txn reset released");

      // ADD wrap and JNC
      issue(0, 2, 0, 0, 4'hE, 0);
      issue(0, 6, 0, 0, 3, 0);
      peek(0, 0, val);
      check("add_wrap_r0", val, 32'h1);
      check("add_wrap_carry", 32'(a_carry), 32'd1);
      issue(0, 11, 0, 0, 5, 0);
      check("jnc_not_taken_pc", 32'(a_pc), 32'h3);
      check("jnc_clears_carry", 32'(a_carry), 32'd0);
      issue(0, 11, 0, 0, 5, 0);
      check("jnc_taken_pc", 32'(a_pc), 32'h5);

      // Back-to-back IN / MOV / OUT
      issue(0, 3, 1, 0, 0, 9);
      issue(0, 1, 0, 1, 0, 0);
      issue(0, 4, 0, 0, 0, 0);
      check("b2b_out", 32'(a_out), 32'h9);

      // Shifts, including the clamped amount
      issue(0, 2, 0, 0, 4'hB, 0);
      issue(0, 8, 0, 0, 2, 0);
      peek(0, 0, val);
      check("shl2_r0", val, 32'hC);
      check("shl2_carry", 32'(a_carry), 32'd0);
      issue(0, 9, 0, 0, 9, 0);
      peek(0, 0, val);
      check("shr_clamp_r0", val, 32'h0);
      check("shr_clamp_carry", 32'(a_carry), 32'd1);

      // Asynchronous reset with live state, then NOP
      issue(0, 2, 1, 0, 7, 0);
      rst_n = 1'b0;
      #1;
      check_reset_state();
      @(negedge clk); rst_n = 1'b1;
      issue(0, 0, 0, 0, 0, 0);
      check("nop_after_rst_pc", 32'(a_pc), 32'h1);

      // Reset while the last shift step is pending
      issue(0, 2, 0, 0, 4'hF, 0);
      drive(0, 1'b1, 8, 0, 0, 2, 0);
      @(posedge clk); #1;
      drive(0, 1'b0, 0, 0, 0, 0, 0);
      check("shift_busy_ready", 32'(a_ready), 32'd0);
      @(posedge clk); #1;
      peek(0, 0, val);
      check("shift_partial_r0", val, 32'hE);
      rst_n = 1'b0;
      #1;
      check_reset_state();
      @(posedge clk); #1;
      check("no_retire_after_rst", 32'(a_retire), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      $display("txn reset during shift");

      // Wide configuration
      issue(1, 2, 2, 0, 8'h20, 0);
      issue(1, 2, 3, 0, 8'hF0, 0);
      issue(1, 7, 3, 2, 0, 0);
      peek(1, 3, val);
      check("wide_add_r3", val, 32'h10);
      check("wide_add_carry", 32'(b_carry), 32'd1);
      issue(1, 10, 0, 0, 8'hFF, 0);
      check("wide_jmp_pc", 32'(b_pc), 32'h3F);
      issue(1, 0, 0, 0, 0, 0);
      check("wide_pc_wrap", 32'(b_pc), 32'h0);

      // Randomized streams on both instances
      for (int i = 0; i < 300; i++) begin
         u = (i % 3 == 0) ? 1 : 0;
         if ($urandom_range(0, 5) == 0) begin
            idle(u);
         end else begin
            op = $urandom_range(0, 15);
            if ((op == 8 || op == 9) && $urandom_range(0, 1) == 1)
               imm = $urandom_range(0, dw(u) + 2);
            else
               imm = $urandom_range(0, 255);
            issue(u, op, $urandom_range(0, 3), $urandom_range(0, 3), imm, $urandom_range(0, 255));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
